// File: rtl/bi_ser_pkg.sv
// Shared types and constants for the bidirectional PISO serializer.
// Bit-order encoding matches the receive-side shift register.
package bi_ser_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bi_piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO serializer.
// The master drives words and the shift enable; the slave is the serializer.
interface bi_piso_serializer_if #(
    parameter int unsigned MSB = 8
);

    logic           load_valid;
    logic           load_ready;
    logic [MSB-1:0] load_data;
    logic           load_dir;
    logic           en;
    logic           sd;
    logic           sd_valid;
    logic           sd_last;
    logic           busy;

    modport master (
        output load_valid,
        output load_data,
        output load_dir,
        output en,
        input  load_ready,
        input  sd,
        input  sd_valid,
        input  sd_last,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dir,
        input  en,
        output load_ready,
        output sd,
        output sd_valid,
        output sd_last,
        output busy
    );

endinterface

// File: rtl/bi_ser_hold.sv
// Single-entry holding buffer for the next word and its bit order.
// Clear wins over load; the owner never asserts both on a useful cycle.
module bi_ser_hold #(
    parameter int unsigned MSB = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           load,
    input  logic           clear,
    input  logic [MSB-1:0] wdata,
    input  logic           wdir,
    output logic           valid,
    output logic [MSB-1:0] data,
    output logic           dir
);

    logic           valid_q;
    logic [MSB-1:0] data_q;
    logic           dir_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dir_q   <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= wdata;
            dir_q   <= wdir;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign dir   = dir_q;

endmodule

// File: rtl/bi_piso_serializer.sv
// Parallel-in serial-out shifter with selectable bit order and a one-word
// holding buffer so consecutive frames follow each other without a gap.
module bi_piso_serializer
    import bi_ser_pkg::*;
#(
    parameter int unsigned MSB = 8
) (
    input logic                  clk,
    input logic                  rstn,
    bi_piso_serializer_if.slave  bus
);

    localparam int unsigned     CntW    = $clog2(MSB);
    localparam logic [CntW-1:0] CntLast = CntW'(MSB - 1);

    state_e          state_q, state_d;
    logic [MSB-1:0]  sreg_q, sreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;

    logic            hold_valid;
    logic [MSB-1:0]  hold_data;
    logic            hold_dir;
    logic            hold_load;
    logic            hold_clear;

    logic            accept;
    logic            xfer;
    logic            last_xfer;
    logic [MSB-1:0]  sreg_shifted;

    assign accept    = bus.load_valid && !hold_valid;
    assign xfer      = (state_q == SHIFT) && bus.en;
    assign last_xfer = xfer && (cnt_q == CntLast);

    assign sreg_shifted = (dir_q == DIR_MSB_FIRST) ? {sreg_q[MSB-2:0], 1'b0}
                                                   : {1'b0, sreg_q[MSB-1:1]};

    bi_ser_hold #(
        .MSB (MSB)
    ) u_hold (
        .clk   (clk),
        .rstn  (rstn),
        .load  (hold_load),
        .clear (hold_clear),
        .wdata (bus.load_data),
        .wdir  (bus.load_dir),
        .valid (hold_valid),
        .data  (hold_data),
        .dir   (hold_dir)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = bus.load_data;
                    dir_d   = bus.load_dir;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    // Held word takes priority; a fresh word may chain in only if the buffer is empty.
                    if (hold_valid) begin
                        sreg_d     = hold_data;
                        dir_d      = hold_dir;
                        cnt_d      = '0;
                        hold_clear = 1'b1;
                    end else if (accept) begin
                        sreg_d = bus.load_data;
                        dir_d  = bus.load_dir;
                        cnt_d  = '0;
                    end else begin
                        sreg_d  = sreg_shifted;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                    hold_load = accept;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready = !hold_valid;
    assign bus.sd_valid   = xfer;
    assign bus.sd         = xfer && ((dir_q == DIR_LSB_FIRST) ? sreg_q[0] : sreg_q[MSB-1]);
    assign bus.sd_last    = last_xfer;
    assign bus.busy       = (state_q == SHIFT) || hold_valid;

endmodule

// File: tb/tb_bi_piso_serializer.sv
// Self-checking bench: a queue of pending frame bits predicts every output each
// cycle; a behavioural receiver checks loopback, and literal frames pin the model.
module tb_bi_piso_serializer;

    localparam int MSB = 8;

    typedef struct packed {
        logic           b;
        logic           last;
        logic           dir;
        logic [MSB-1:0] word;
    } ent_t;

    logic clk;
    logic rstn;

    bi_piso_serializer_if #(.MSB(MSB)) bus ();

    bi_piso_serializer #(
        .MSB (MSB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Pending serial bits, front = bit currently on sd when enabled.
    ent_t q[$];
    ent_t me;

    logic [MSB-1:0] seq = '0;
    logic [MSB-1:0] rx  = '0;
    logic [MSB-1:0] frames [0:1023];
    int             nfr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: consume a bit on each enabled cycle, append a whole word on acceptance.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
        end else begin
            automatic bit ready = (q.size() <= MSB);
            if (q.size() > 0 && bus.en) void'(q.pop_front());
            if (bus.load_valid && ready) begin
                for (int i = 0; i < MSB; i++) begin
                    me.dir  = bus.load_dir;
                    me.word = bus.load_data;
                    me.last = (i == MSB - 1);
                    me.b    = bus.load_dir ? bus.load_data[i] : bus.load_data[MSB-1-i];
                    q.push_back(me);
                end
            end
        end
    end

    // Compare every cycle away from the active edge; also run the loopback receiver.
    always @(negedge clk) begin
        automatic logic exp_v    = (q.size() > 0) && bus.en;
        automatic logic exp_sd   = exp_v ? q[0].b : 1'b0;
        automatic logic exp_last = exp_v ? q[0].last : 1'b0;
        chk("sd_valid", 32'(bus.sd_valid), 32'(exp_v));
        chk("sd", 32'(bus.sd), 32'(exp_sd));
        chk("sd_last", 32'(bus.sd_last), 32'(exp_last));
        chk("busy", 32'(bus.busy), 32'(q.size() > 0));
        chk("load_ready", 32'(bus.load_ready), 32'(q.size() <= MSB));
        if (bus.sd_valid) begin
            seq = {seq[MSB-2:0], bus.sd};
            if (q.size() > 0) begin
                rx = q[0].dir ? {bus.sd, rx[MSB-1:1]} : {rx[MSB-2:0], bus.sd};
            end
            if (bus.sd_last) begin
                if (nfr < 1024) frames[nfr] = seq;
                nfr++;
                if (q.size() > 0) chk("loopback", 32'(rx), 32'(q[0].word));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [MSB-1:0] d, input logic dr);
        bit ok = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_dir   = dr;
        for (int k = 0; k < 64 && !ok; k++) begin
            ok = (q.size() <= MSB);
            cyc();
        end
        bus.load_valid = 1'b0;
        if (!ok) chk("offer_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bus.en = 1'b1;
        for (int k = 0; k < 200 && q.size() > 0; k++) cyc();
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_frame(input string nm, input int idx, input logic [MSB-1:0] lit);
        if (idx < nfr && idx < 1024) chk(nm, 32'(frames[idx]), 32'(lit));
        else chk({nm, "_missing"}, 32'(nfr), 32'(idx + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        int acc;
        int budget;
        rstn           = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_dir   = 1'b0;
        bus.en         = 1'b0;
        #3;
        chk("rst_sd_valid", 32'(bus.sd_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        #20 rstn = 1'b1;
        cyc();

        // 1: MSB first, en held high
        bus.en = 1'b1;
        f0 = nfr;
        offer(8'hA5, 1'b0);
        drain();
        chk("t1_frames", 32'(nfr - f0), 32'd1);
        chk_frame("t1_bits", f0, 8'b1010_0101);

        // 2: LSB first
        f0 = nfr;
        offer(8'hC4, 1'b1);
        drain();
        chk_frame("t2_bits", f0, 8'b0010_0011);

        // 3: back-to-back, second word goes through the holding buffer
        f0 = nfr;
        offer(8'hC4, 1'b1);
        offer(8'h5A, 1'b0);
        chk("t3_held_ready", 32'(bus.load_ready), 32'd0);
        drain();
        chk("t3_frames", 32'(nfr - f0), 32'd2);
        chk_frame("t3_first", f0, 8'b0010_0011);
        chk_frame("t3_second", f0 + 1, 8'b0101_1010);

        // 4: stall after bit 3
        f0 = nfr;
        offer(8'hF0, 1'b0);
        cyc(); cyc(); cyc();
        bus.en = 1'b0;
        cyc(); cyc(); cyc();
        chk("t4_stall_valid", 32'(bus.sd_valid), 32'd0);
        chk("t4_stall_sd", 32'(bus.sd), 32'd0);
        drain();
        chk_frame("t4_bits", f0, 8'b1111_0000);

        // 5: asynchronous reset mid-frame
        offer(8'hFF, 1'b0);
        cyc(); cyc(); cyc();
        #3 rstn = 1'b0;
        #1;
        chk("t5_sd_valid", 32'(bus.sd_valid), 32'd0);
        chk("t5_sd", 32'(bus.sd), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_ready", 32'(bus.load_ready), 32'd1);
        cyc(); cyc();
        #2 rstn = 1'b1;
        cyc();
        f0 = nfr;
        offer(8'h0F, 1'b1);
        drain();
        chk("t5_frames", 32'(nfr - f0), 32'd1);
        chk_frame("t5_bits", f0, 8'b1111_0000);

        // 6: random loopback
        f0     = nfr;
        acc    = 0;
        budget = 0;
        while (acc < 200 && budget < 20000) begin
            bus.load_valid = ($urandom_range(9) < 6);
            bus.load_data  = MSB'($urandom);
            bus.load_dir   = 1'($urandom);
            bus.en         = ($urandom_range(3) != 0);
            if (bus.load_valid && q.size() <= MSB) acc++;
            cyc();
            budget++;
        end
        bus.load_valid = 1'b0;
        if (acc < 200) chk("t6_timeout", 32'(acc), 32'd200);
        drain();
        chk("t6_frames", 32'(nfr - f0), 32'd200);

        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
